rr_grant_sequencer: RTL and testbench
=====================================

// Module: rr_grant_sequencer
// PURPOSE
//  Round-robin arbiter/sequencer sharing one resource among WIDTH requesters.
//  Builds its priority mask with the one-hot -> lower-thermometer mask function
//  (out[0]=~in[0]; out[i]=out[i-1]&~in[i]), wrapped in a registered grant FSM.
//  Holds each grant until the owner releases it; the releasing owner drops to lowest priority.
//  Sits between requesting datapath clients and the shared unit; grant drives the unit's input mux.
// PARAMETERS
//  WIDTH        8   number of requesters (>=2)
//  HOLD_CYCLES  16  max cycles a grant may be held; used only with RR_GRANT_TIMEOUT_EN
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               async active-low reset
//  req        in   WIDTH           request per requester, level-held until served
//  done       in   1               owner release strobe; ignored when gnt_valid=0
//  gnt        out  WIDTH           registered one-hot grant, all-zero when idle
//  gnt_valid  out  1               registered, =|gnt
//  gnt_idx    out  $clog2(WIDTH)   binary index of gnt; 0 when idle
//  timeout    out  1               one-cycle pulse on forced revoke; tied 0 without macro
// BEHAVIOUR
//  - Reset (async assert, sync deassert): gnt=0, gnt_valid=0, gnt_idx=0, timeout=0,
//    state=IDLE, last-grant pointer=one-hot bit WIDTH-1, so requester 0 wins first.
//  - Priority: mask = ~(thermo(last)|last), i.e. bits strictly above last grant.
//    winner = lowest set bit of (req&mask) if nonzero, else lowest set bit of req.
//  - FSM states IDLE, BUSY:
//    IDLE: |req at edge N -> gnt=winner, gnt_valid=1, pointer=winner, BUSY at N+1.
//          No req -> stay IDLE, outputs 0.
//    BUSY: hold gnt unchanged while req[gnt_idx]=1 and done=0.
//          Release = done=1 OR req[gnt_idx]=0. On release at edge N:
//          if (req & ~gnt)!=0 -> new winner granted at N+1 (back-to-back, no idle cycle);
//          else -> gnt=0, IDLE at N+1.
//  - Latency: request -> grant = 1 cycle from IDLE; release -> next grant = 1 cycle.
//  - done and req[gnt_idx] high in the same cycle: done wins, owner released. The owner may be
//    re-granted in that same arbitration only if it is the sole requester.
//  - Requests from non-owners while BUSY are ignored until release; they never corrupt gnt.
//  - Pointer wraps: after bit WIDTH-1 the mask is all-zero, so search restarts at bit 0.
//  - gnt is always one-hot or zero; gnt_idx always matches gnt.
//  - Async reset mid-grant: gnt drops immediately, pointer returns to reset value.
// CONFIGURATION
//  RR_GRANT_TIMEOUT_EN defined: hold counter counts cycles in BUSY and clears on every new
//    grant. When a grant has been held HOLD_CYCLES cycles with no release, it is
//    force-released: timeout=1 for one cycle, coincident with the re-arbitration edge.
//    Re-arbitration follows the normal release rules. If the timed-out owner is the sole
//    requester, it is re-granted.
//  RR_GRANT_TIMEOUT_EN undefined: no counter is built, timeout is tied 0, and grants
//    are held indefinitely.
// TESTING (WIDTH=4, HOLD_CYCLES=3)
//  1 reset, req=0101 -> next cycle gnt=0001, gnt_idx=0, gnt_valid=1
//  2 req=0101 held, done=0 for 5 cycles -> gnt stays 0001; done pulse -> next cycle gnt=0100
//  3 req=1111 constant, done pulsed each granted cycle -> gnt 0001,0010,0100,1000,0001
//  4 owner 0010 drops req, no others requesting -> next cycle gnt=0000, gnt_valid=0, IDLE
//  5 rst_n low while gnt=0100 -> gnt=0 at once; release, req=1001 -> gnt=0001
//  6 (RR_GRANT_TIMEOUT_EN) req=0011 held, no done -> 0001 held 3 cycles, timeout=1, then
//    gnt=0010; without macro gnt stays 0001 and timeout stays 0

Source files
------------

// File: rtl/rr_grant_sequencer.sv
// rr_grant_sequencer: round-robin grant sequencer for one shared resource.
// A grant is held until the owner releases it, either by pulsing done or by
// dropping its request. The releasing owner then becomes lowest priority.
// Optional feature macro: RR_GRANT_TIMEOUT_EN. When it is defined, a grant that
// is held for HOLD_CYCLES cycles is revoked and timeout pulses for one cycle.
//
// state  | meaning
// S_IDLE | no grant outstanding, arbitrate on any request
// S_BUSY | one requester owns the resource, wait for its release
module rr_grant_sequencer #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req,
  input  logic                     done,
  output logic [WIDTH-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(WIDTH)-1:0] gnt_idx,
  output logic                     timeout
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_gnt;
  logic             r_gnt_valid;
  logic [IW-1:0]    r_gnt_idx;
  logic [WIDTH-1:0] r_last;

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_req_masked;
  logic [WIDTH-1:0] w_cand;
  logic [WIDTH-1:0] w_win;
  logic [IW-1:0]    w_win_idx;
  logic             w_natural;
  logic             w_expire;
  logic             w_release;
  logic             w_grant;

  // Bits below a one-hot value, built as a lower-thermometer chain
  function automatic logic [WIDTH-1:0] f_thermo(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] t;
    t[0] = ~v[0];
    for (int i = 1; i < WIDTH; i++) t[i] = t[i-1] & ~v[i];
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] f_lowest(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    logic             found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] f_index(input logic [WIDTH-1:0] oh);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) if (oh[i]) r = IW'(i);
    return r;
  endfunction

  // Only requesters strictly above the last grant get first pick; otherwise wrap to bit 0
  assign w_mask       = ~(f_thermo(r_last) | r_last);
  assign w_req_masked = req & w_mask;
  assign w_cand       = (|w_req_masked) ? w_req_masked : req;
  assign w_win        = f_lowest(w_cand);
  assign w_win_idx    = f_index(w_win);

  // done wins over a still-high request; a dropped request also releases
  assign w_natural = done | ~(|(req & r_gnt));
  assign w_release = (r_state == S_BUSY) && (w_natural || w_expire);
  assign w_grant   = ((r_state == S_IDLE) || w_release) && (|req);

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  logic [CW-1:0] r_hold_cnt;
  logic          r_timeout;

  assign w_expire = (r_hold_cnt == '0);
  assign timeout  = r_timeout;

  // Reload the hold timer on every grant, count down while the owner keeps it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_grant) begin
      r_hold_cnt <= HOLD_LOAD;
    end else if ((r_state == S_BUSY) && (r_hold_cnt != '0)) begin
      r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end
`else
  localparam int unused_hold_cycles = HOLD_CYCLES;

  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  // Grant FSM with registered grant, index, valid and timeout outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
      r_last      <= {1'b1, {(WIDTH-1){1'b0}}};
`ifdef RR_GRANT_TIMEOUT_EN
      r_timeout   <= 1'b0;
`endif
    end else begin
`ifdef RR_GRANT_TIMEOUT_EN
      r_timeout <= w_release && !w_natural;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state     <= S_BUSY;
            r_gnt       <= w_win;
            r_gnt_valid <= 1'b1;
            r_gnt_idx   <= w_win_idx;
            r_last      <= w_win;
          end
        end
        S_BUSY: begin
          if (w_grant) begin
            r_gnt     <= w_win;
            r_gnt_idx <= w_win_idx;
            r_last    <= w_win;
          end else if (w_release) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= '0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= '0;
          r_gnt_valid <= 1'b0;
          r_gnt_idx   <= '0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign gnt_idx   = r_gnt_idx;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Bench for rr_grant_sequencer at WIDTH=4, HOLD_CYCLES=3: directed table,
// hand-written hold/timeout/reset sequences, then random traffic vs. a model.
module tb_rr_grant_sequencer;
  localparam int W    = 4;
  localparam int HOLD = 3;
  localparam int IW   = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  req;
  logic          done;
  logic [W-1:0]  gnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;
  logic          timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] req;
    logic         done;
    logic [W-1:0] exp_gnt;
  } vec_t;

  vec_t tbl[18];

  // reference model state: owner index (-1 idle), last grant, cycles held
  int   m_owner;
  int   m_last;
  int   m_held;
  logic m_to;

  always #5 clk = ~clk;

  rr_grant_sequencer #(.WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] eg, input logic et);
    int ei;
    ei = 0;
    for (int i = 0; i < W; i++) if (eg[i]) ei = i;
    chk({tag, " gnt"}, 32'(gnt), 32'(eg));
    chk({tag, " gnt_idx"}, 32'(gnt_idx), 32'(ei));
    chk({tag, " gnt_valid"}, 32'(gnt_valid), 32'(|eg));
    chk({tag, " timeout"}, 32'(timeout), 32'(et));
  endtask

  task automatic cycle(input logic [W-1:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    @(posedge clk);
    #1;
    chk_out("reset", 4'b0000, 1'b0);
    rst_n = 1'b1;
    m_owner = -1;
    m_last  = W - 1;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  // circular search starting just above the last grant
  function automatic int m_arb(input logic [W-1:0] r, input int last);
    for (int s = 1; s <= W; s++) begin
      int k;
      k = (last + s) % W;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [W-1:0] r, input logic d);
    logic forced;
    logic natural;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (r != '0) begin
        m_owner = m_arb(r, m_last);
        m_last  = m_owner;
        m_held  = 1;
      end
    end else begin
      forced = 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      forced = (m_held >= HOLD);
`endif
      natural = d || !r[m_owner];
      if (natural || forced) begin
        m_to = forced && !natural;
        if (r != '0) begin
          m_owner = m_arb(r, m_last);
          m_last  = m_owner;
          m_held  = 1;
        end else begin
          m_owner = -1;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  initial begin
    logic [W-1:0] r;
    logic         d;
    logic [W-1:0] eg;
    logic [W-1:0] seq_g[7];
    logic         seq_t[7];

    tbl[0]  = '{4'b0101, 1'b0, 4'b0001};
    tbl[1]  = '{4'b0101, 1'b0, 4'b0001};
    tbl[2]  = '{4'b0101, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[6]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[7]  = '{4'b1111, 1'b1, 4'b1000};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[9]  = '{4'b0010, 1'b1, 4'b0010};
    tbl[10] = '{4'b0000, 1'b0, 4'b0000};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000};
    tbl[12] = '{4'b1001, 1'b0, 4'b1000};
    tbl[13] = '{4'b1001, 1'b1, 4'b0001};
    tbl[14] = '{4'b0001, 1'b1, 4'b0001};
    tbl[15] = '{4'b0011, 1'b0, 4'b0001};
    tbl[16] = '{4'b0011, 1'b1, 4'b0010};
    tbl[17] = '{4'b0000, 1'b0, 4'b0000};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].req, tbl[i].done);
      chk_out($sformatf("tbl[%0d]", i), tbl[i].exp_gnt, 1'b0);
    end

`ifdef RR_GRANT_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0101, 1'b0);
      chk_out("hold pre-timeout", 4'b0001, 1'b0);
    end
    cycle(4'b0101, 1'b0);
    chk_out("hold forced", 4'b0100, 1'b1);
    cycle(4'b0101, 1'b1);
    chk_out("hold after done", 4'b0001, 1'b0);

    do_reset();
    seq_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    seq_t = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      cycle(4'b0011, 1'b0);
      chk_out($sformatf("timeout seq[%0d]", i), seq_g[i], seq_t[i]);
    end
    cycle(4'b0001, 1'b0);
    chk_out("sole hold 1", 4'b0001, 1'b0);
    cycle(4'b0001, 1'b0);
    chk_out("sole hold 2", 4'b0001, 1'b0);
    cycle(4'b0001, 1'b0);
    chk_out("sole regrant", 4'b0001, 1'b1);
`else
    do_reset();
    cycle(4'b0101, 1'b0);
    chk_out("hold first", 4'b0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b0101, 1'b0);
      chk_out($sformatf("hold[%0d]", i), 4'b0001, 1'b0);
    end
    cycle(4'b0101, 1'b1);
    chk_out("hold release", 4'b0100, 1'b0);

    do_reset();
    seq_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    seq_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      cycle(4'b0011, 1'b0);
      chk_out($sformatf("no-timeout seq[%0d]", i), seq_g[i], seq_t[i]);
    end
`endif

    // asynchronous reset in the middle of a grant
    do_reset();
    cycle(4'b0100, 1'b0);
    chk_out("pre async reset", 4'b0100, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async reset", 4'b0000, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(4'b1001, 1'b0);
    chk_out("after async reset", 4'b0001, 1'b0);

    // random traffic against the model
    do_reset();
    r = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 1) == 0) r = W'($urandom_range(0, 15));
      d = ($urandom_range(0, 3) == 0);
      req  = r;
      done = d;
      @(posedge clk);
      model_step(r, d);
      #1;
      eg = (m_owner >= 0) ? W'(1 << m_owner) : '0;
      chk_out($sformatf("rand[%0d]", n), eg, m_to);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
